// File: rtl/lsu_defines.sv
// Shared encodings and DTCM geometry for the load/store unit.
package lsu_defines;

  localparam int DTCM_RAM_DW     = 32;
  localparam int DTCM_RAM_MW     = DTCM_RAM_DW / 8;
  localparam int DTCM_ADDR_WIDTH = 16;

  // Access size as carried by the execute stage; 2'b11 is never legal.
  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_ILL  = 2'b11
  } lsu_size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CMD  = 2'b01,
    ST_RSP  = 2'b10,
    ST_WB   = 2'b11
  } lsu_state_e;

  // An illegal size is reported through the same exception path as a
  // misaligned address so the core only has one trap cause to handle.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] addr_lo);
    logic mis;
    case (size)
      SIZE_BYTE: mis = 1'b0;
      SIZE_HALF: mis = addr_lo[0];
      SIZE_WORD: mis = |addr_lo;
      default:   mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_ld_extract.sv
// Load data alignment: moves the addressed lane down to bit 0 and extends it.
module lsu_ld_extract
  import lsu_defines::*;
#(
  parameter int DW = DTCM_RAM_DW
) (
  input  logic [DW-1:0] rdata,
  input  logic [1:0]    addr_lo,
  input  logic [1:0]    size,
  input  logic          ld_unsigned,
  output logic [DW-1:0] ld_data
);

  logic [DW-1:0] shifted;
  logic          sign_b;
  logic          sign_h;

  // right-justify the addressed lane, then sign- or zero-extend it
  always_comb begin
    shifted = rdata >> {addr_lo, 3'b000};
    sign_b  = ~ld_unsigned & shifted[7];
    sign_h  = ~ld_unsigned & shifted[15];
    case (size)
      SIZE_BYTE: ld_data = {{(DW-8){sign_b}}, shifted[7:0]};
      SIZE_HALF: ld_data = {{(DW-16){sign_h}}, shifted[15:0]};
      default:   ld_data = shifted;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one DTCM access in flight, registered outputs throughout.
module lsu
  import lsu_defines::*;
#(
  parameter int DW = DTCM_RAM_DW,
  parameter int MW = DTCM_RAM_MW,
  parameter int AW = DTCM_ADDR_WIDTH
) (
  input  logic          clk,
  input  logic          rst_n,

  input  logic          exu2lsu_valid,
  output logic          exu2lsu_ready,
  input  logic          exu2lsu_load,
  input  logic [1:0]    exu2lsu_size,
  input  logic          exu2lsu_unsigned,
  input  logic [AW-1:0] exu2lsu_addr,
  input  logic [DW-1:0] exu2lsu_wdata,
  input  logic [4:0]    exu2lsu_rd,

  output logic          lsu2dtcm_cmd_valid,
  input  logic          lsu2dtcm_cmd_ready,
  output logic          lsu2dtcm_cmd_read,
  output logic [AW-1:0] lsu2dtcm_cmd_addr,
  output logic [MW-1:0] lsu2dtcm_cmd_wmask,
  output logic [DW-1:0] lsu2dtcm_cmd_wdata,

  input  logic          lsu2dtcm_rsp_valid,
  output logic          lsu2dtcm_rsp_ready,
  input  logic [DW-1:0] lsu2dtcm_rsp_rdata,

  output logic          lsu2wb_valid,
  input  logic          lsu2wb_ready,
  output logic [4:0]    lsu2wb_rd,
  output logic          lsu2wb_wen,
  output logic [DW-1:0] lsu2wb_rdata,
  output logic          lsu2wb_misalign
);

  lsu_state_e    state_q;
  lsu_state_e    state_d;
  logic [1:0]    size_p0;
  logic          unsigned_p0;
  logic          accept;
  logic          misalign_req;
  logic          rsp_take;
  logic [DW-1:0] ld_data;

  // Byte-lane enables for a store; size 11 never reaches the DTCM.
  function automatic logic [MW-1:0] wmask_gen(input logic [1:0] size,
                                              input logic [1:0] lo);
    logic [MW-1:0] m;
    case (size)
      SIZE_BYTE: m = MW'(1) << lo;
      SIZE_HALF: m = MW'(3) << lo;
      default:   m = '1;
    endcase
    return m;
  endfunction

  // Replicate the right-justified store data into every lane so the mask
  // alone selects which bytes the RAM actually writes.
  function automatic logic [DW-1:0] wdata_gen(input logic [1:0]    size,
                                              input logic [DW-1:0] wd);
    logic [DW-1:0] d;
    case (size)
      SIZE_BYTE: d = {(DW/8){wd[7:0]}};
      SIZE_HALF: d = {(DW/16){wd[15:0]}};
      default:   d = wd;
    endcase
    return d;
  endfunction

  assign accept       = exu2lsu_valid && exu2lsu_ready;
  assign misalign_req = is_misaligned(exu2lsu_size, exu2lsu_addr[1:0]);
  assign rsp_take     = ((state_q == ST_CMD) && lsu2dtcm_cmd_ready && lsu2dtcm_rsp_valid)
                     || ((state_q == ST_RSP) && lsu2dtcm_rsp_valid);

  lsu_ld_extract #(.DW(DW)) u_ld_extract (
    .rdata       (lsu2dtcm_rsp_rdata),
    .addr_lo     (lsu2dtcm_cmd_addr[1:0]),
    .size        (size_p0),
    .ld_unsigned (unsigned_p0),
    .ld_data     (ld_data)
  );

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // next-state decode; a misaligned request skips the DTCM entirely
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = misalign_req ? ST_WB : ST_CMD;
      ST_CMD:  if (lsu2dtcm_cmd_ready) state_d = lsu2dtcm_rsp_valid ? ST_WB : ST_RSP;
      ST_RSP:  if (lsu2dtcm_rsp_valid) state_d = ST_WB;
      ST_WB:   if (lsu2wb_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // handshake flags registered from the next state so none depends on an input combinationally
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      exu2lsu_ready      <= 1'b0;
      lsu2dtcm_cmd_valid <= 1'b0;
      lsu2dtcm_rsp_ready <= 1'b0;
      lsu2wb_valid       <= 1'b0;
    end else begin
      exu2lsu_ready      <= (state_d == ST_IDLE);
      lsu2dtcm_cmd_valid <= (state_d == ST_CMD);
      lsu2dtcm_rsp_ready <= (state_d == ST_CMD) || (state_d == ST_RSP);
      lsu2wb_valid       <= (state_d == ST_WB);
    end
  end

  // request latch: command fields are built once at accept and held until the next accept
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lsu2dtcm_cmd_read  <= 1'b0;
      lsu2dtcm_cmd_addr  <= '0;
      lsu2dtcm_cmd_wmask <= '0;
      lsu2dtcm_cmd_wdata <= '0;
      size_p0            <= '0;
      unsigned_p0        <= 1'b0;
      lsu2wb_rd          <= '0;
    end else if (accept) begin
      lsu2dtcm_cmd_read  <= exu2lsu_load;
      lsu2dtcm_cmd_addr  <= exu2lsu_addr;
      lsu2dtcm_cmd_wmask <= exu2lsu_load ? '0 : wmask_gen(exu2lsu_size, exu2lsu_addr[1:0]);
      lsu2dtcm_cmd_wdata <= exu2lsu_load ? '0 : wdata_gen(exu2lsu_size, exu2lsu_wdata);
      size_p0            <= exu2lsu_size;
      unsigned_p0        <= exu2lsu_unsigned;
      lsu2wb_rd          <= exu2lsu_rd;
    end
  end

  // write-back payload: cleared at accept, filled from the DTCM response for loads
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lsu2wb_wen      <= 1'b0;
      lsu2wb_rdata    <= '0;
      lsu2wb_misalign <= 1'b0;
    end else if (accept) begin
      lsu2wb_wen      <= 1'b0;
      lsu2wb_rdata    <= '0;
      lsu2wb_misalign <= misalign_req;
    end else if (rsp_take) begin
      lsu2wb_wen      <= lsu2dtcm_cmd_read;
      lsu2wb_rdata    <= lsu2dtcm_cmd_read ? ld_data : '0;
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu and its standalone load extractor.
module tb_lsu;
  import lsu_defines::*;

  localparam int DW = 32;
  localparam int MW = 4;
  localparam int AW = DTCM_ADDR_WIDTH;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          exu2lsu_valid, exu2lsu_ready, exu2lsu_load, exu2lsu_unsigned;
  logic [1:0]    exu2lsu_size;
  logic [AW-1:0] exu2lsu_addr;
  logic [DW-1:0] exu2lsu_wdata;
  logic [4:0]    exu2lsu_rd;
  logic          lsu2dtcm_cmd_valid, lsu2dtcm_cmd_ready, lsu2dtcm_cmd_read;
  logic [AW-1:0] lsu2dtcm_cmd_addr;
  logic [MW-1:0] lsu2dtcm_cmd_wmask;
  logic [DW-1:0] lsu2dtcm_cmd_wdata;
  logic          lsu2dtcm_rsp_valid, lsu2dtcm_rsp_ready;
  logic [DW-1:0] lsu2dtcm_rsp_rdata;
  logic          lsu2wb_valid, lsu2wb_ready, lsu2wb_wen, lsu2wb_misalign;
  logic [4:0]    lsu2wb_rd;
  logic [DW-1:0] lsu2wb_rdata;

  logic [31:0]   x_rdata, x_data;
  logic [1:0]    x_lo, x_size;
  logic          x_uns;

  typedef struct {
    logic [4:0]  rd;
    logic        wen;
    logic [31:0] rdata;
    logic        mis;
  } wb_t;

  wb_t sb[$];
  wb_t obs[$];
  wb_t mon_w, o, e;
  int  n_checks = 0;
  int  n_fail = 0;
  int  completions = 0;
  int  cmd_cycles = 0;

  always #5 clk = ~clk;

  lsu #(.DW(DW), .MW(MW), .AW(AW)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .exu2lsu_valid      (exu2lsu_valid),
    .exu2lsu_ready      (exu2lsu_ready),
    .exu2lsu_load       (exu2lsu_load),
    .exu2lsu_size       (exu2lsu_size),
    .exu2lsu_unsigned   (exu2lsu_unsigned),
    .exu2lsu_addr       (exu2lsu_addr),
    .exu2lsu_wdata      (exu2lsu_wdata),
    .exu2lsu_rd         (exu2lsu_rd),
    .lsu2dtcm_cmd_valid (lsu2dtcm_cmd_valid),
    .lsu2dtcm_cmd_ready (lsu2dtcm_cmd_ready),
    .lsu2dtcm_cmd_read  (lsu2dtcm_cmd_read),
    .lsu2dtcm_cmd_addr  (lsu2dtcm_cmd_addr),
    .lsu2dtcm_cmd_wmask (lsu2dtcm_cmd_wmask),
    .lsu2dtcm_cmd_wdata (lsu2dtcm_cmd_wdata),
    .lsu2dtcm_rsp_valid (lsu2dtcm_rsp_valid),
    .lsu2dtcm_rsp_ready (lsu2dtcm_rsp_ready),
    .lsu2dtcm_rsp_rdata (lsu2dtcm_rsp_rdata),
    .lsu2wb_valid       (lsu2wb_valid),
    .lsu2wb_ready       (lsu2wb_ready),
    .lsu2wb_rd          (lsu2wb_rd),
    .lsu2wb_wen         (lsu2wb_wen),
    .lsu2wb_rdata       (lsu2wb_rdata),
    .lsu2wb_misalign    (lsu2wb_misalign)
  );

  lsu_ld_extract #(.DW(32)) u_x (
    .rdata       (x_rdata),
    .addr_lo     (x_lo),
    .size        (x_size),
    .ld_unsigned (x_uns),
    .ld_data     (x_data)
  );

  // record every write-back handshake and every cycle a command is offered
  always @(negedge clk) begin
    if (rst_n && lsu2wb_valid && lsu2wb_ready) begin
      mon_w.rd    = lsu2wb_rd;
      mon_w.wen   = lsu2wb_wen;
      mon_w.rdata = lsu2wb_rdata;
      mon_w.mis   = lsu2wb_misalign;
      obs.push_back(mon_w);
      completions++;
    end
    if (rst_n && lsu2dtcm_cmd_valid) cmd_cycles++;
  end

  // hard stop if something hangs
  initial begin
    #400000;
    $display("FAIL watchdog: still running at %0t, limit 400000", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic drive_req(input logic ld, input logic [1:0] sz, input logic uns,
                           input logic [AW-1:0] a, input logic [31:0] wd, input logic [4:0] rd);
    @(posedge clk); #1;
    exu2lsu_load = ld; exu2lsu_size = sz; exu2lsu_unsigned = uns;
    exu2lsu_addr = a;  exu2lsu_wdata = wd; exu2lsu_rd = rd;
    exu2lsu_valid = 1'b1;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (exu2lsu_ready) break;
    end
    @(posedge clk); #1;
    exu2lsu_valid = 1'b0;
  endtask

  task automatic push_exp(input logic [4:0] rd, input logic wen, input logic [31:0] rdata, input logic mis);
    wb_t w;
    w.rd = rd; w.wen = wen; w.rdata = rdata; w.mis = mis;
    sb.push_back(w);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    exu2lsu_valid = 0; exu2lsu_load = 0; exu2lsu_size = 0; exu2lsu_unsigned = 0;
    exu2lsu_addr = 0; exu2lsu_wdata = 0; exu2lsu_rd = 0;
    lsu2dtcm_cmd_ready = 0; lsu2dtcm_rsp_valid = 0; lsu2dtcm_rsp_rdata = 0; lsu2wb_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({exu2lsu_ready, lsu2dtcm_cmd_valid, lsu2dtcm_cmd_read, lsu2dtcm_rsp_ready,
         lsu2wb_valid, lsu2wb_wen, lsu2wb_misalign} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b, want 0000000", {exu2lsu_ready, lsu2dtcm_cmd_valid,
               lsu2dtcm_cmd_read, lsu2dtcm_rsp_ready, lsu2wb_valid, lsu2wb_wen, lsu2wb_misalign});
    end
    n_checks++;
    if ({lsu2dtcm_cmd_addr, lsu2dtcm_cmd_wmask, lsu2dtcm_cmd_wdata, lsu2wb_rd, lsu2wb_rdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: addr=%h wmask=%b wdata=%h rd=%0d rdata=%h, want all zero",
               lsu2dtcm_cmd_addr, lsu2dtcm_cmd_wmask, lsu2dtcm_cmd_wdata, lsu2wb_rd, lsu2wb_rdata);
    end
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_ld_extract;
    logic [31:0] rd_t [8] = '{32'h80FF7F01, 32'h80FF7F01, 32'h80FF7F01, 32'h80FF7F01,
                              32'h80FF7F01, 32'h80FF7F01, 32'h80FF7F01, 32'h80FF7F01};
    logic [1:0]  lo_t [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd2, 2'd2, 2'd0};
    logic [1:0]  sz_t [8] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b10};
    logic        un_t [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] ex_t [8] = '{32'h00000001, 32'h0000007F, 32'hFFFFFFFF, 32'h00000080,
                              32'h00007F01, 32'hFFFF80FF, 32'h000080FF, 32'h80FF7F01};
    for (int i = 0; i < 8; i++) begin
      x_rdata = rd_t[i]; x_lo = lo_t[i]; x_size = sz_t[i]; x_uns = un_t[i];
      #1;
      n_checks++;
      if (x_data !== ex_t[i]) begin
        n_fail++;
        $display("FAIL ld_extract[%0d]: got %h, want %h", i, x_data, ex_t[i]);
      end
    end
  endtask

  task automatic test_load_word;
    lsu2dtcm_cmd_ready = 1; lsu2dtcm_rsp_valid = 1; lsu2dtcm_rsp_rdata = 32'h87654321; lsu2wb_ready = 1;
    push_exp(5'd5, 1'b1, 32'h87654321, 1'b0);
    drive_req(1'b1, SIZE_WORD, 1'b0, 16'h0010, 32'h0, 5'd5);
    @(negedge clk);
    n_checks++;
    if ({lsu2dtcm_cmd_valid, lsu2dtcm_cmd_read, lsu2dtcm_cmd_wmask, lsu2dtcm_cmd_addr, lsu2wb_valid}
        !== {1'b1, 1'b1, 4'b0000, 16'h0010, 1'b0}) begin
      n_fail++;
      $display("FAIL lw_cmd: valid=%b read=%b wmask=%b addr=%h wbv=%b, want 1 1 0000 0010 0",
               lsu2dtcm_cmd_valid, lsu2dtcm_cmd_read, lsu2dtcm_cmd_wmask, lsu2dtcm_cmd_addr, lsu2wb_valid);
    end
    @(negedge clk);
    n_checks++;
    if (lsu2wb_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL lw_latency: wb_valid=%b two cycles after accept, want 1", lsu2wb_valid);
    end
    for (int t = 0; t < 50 && obs.size() == 0; t++) @(negedge clk);
    n_checks++;
    if (obs.size() == 0 || sb.size() == 0) begin
      n_fail++;
      $display("FAIL lw_wb: observed=%0d expected=%0d entries", obs.size(), sb.size());
    end else begin
      o = obs.pop_front(); e = sb.pop_front();
      if (o.rd !== e.rd || o.wen !== e.wen || o.rdata !== e.rdata || o.mis !== e.mis) begin
        n_fail++;
        $display("FAIL lw_wb: got rd=%0d wen=%b rdata=%h mis=%b, want rd=%0d wen=%b rdata=%h mis=%b",
                 o.rd, o.wen, o.rdata, o.mis, e.rd, e.wen, e.rdata, e.mis);
      end
    end
  endtask

  task automatic test_load_byte;
    lsu2dtcm_cmd_ready = 1; lsu2dtcm_rsp_valid = 1; lsu2dtcm_rsp_rdata = 32'h80FFFFFF; lsu2wb_ready = 1;
    push_exp(5'd1, 1'b1, 32'hFFFFFF80, 1'b0);
    drive_req(1'b1, SIZE_BYTE, 1'b0, 16'h0013, 32'h0, 5'd1);
    push_exp(5'd2, 1'b1, 32'h00000080, 1'b0);
    drive_req(1'b1, SIZE_BYTE, 1'b1, 16'h0013, 32'h0, 5'd2);
    for (int i = 0; i < 2; i++) begin
      for (int t = 0; t < 50 && obs.size() == 0; t++) @(negedge clk);
      n_checks++;
      if (obs.size() == 0 || sb.size() == 0) begin
        n_fail++;
        $display("FAIL lb_wb[%0d]: observed=%0d expected=%0d entries", i, obs.size(), sb.size());
      end else begin
        o = obs.pop_front(); e = sb.pop_front();
        if (o.rd !== e.rd || o.wen !== e.wen || o.rdata !== e.rdata || o.mis !== e.mis) begin
          n_fail++;
          $display("FAIL lb_wb[%0d]: got rd=%0d wen=%b rdata=%h mis=%b, want rd=%0d wen=%b rdata=%h mis=%b",
                   i, o.rd, o.wen, o.rdata, o.mis, e.rd, e.wen, e.rdata, e.mis);
        end
      end
    end
  endtask

  task automatic test_store;
    logic [15:0] a_t  [2] = '{16'h0022, 16'h0001};
    logic [1:0]  sz_t [2] = '{2'b01, 2'b00};
    logic [31:0] wd_t [2] = '{32'h0000BEEF, 32'h000000A5};
    logic [3:0]  mk_t [2] = '{4'b1100, 4'b0010};
    logic [31:0] cw_t [2] = '{32'hBEEFBEEF, 32'hA5A5A5A5};
    lsu2dtcm_cmd_ready = 1; lsu2dtcm_rsp_valid = 1; lsu2dtcm_rsp_rdata = 32'hFFFFFFFF; lsu2wb_ready = 1;
    for (int i = 0; i < 2; i++) begin
      push_exp(5'(7 + i), 1'b0, 32'h0, 1'b0);
      drive_req(1'b0, sz_t[i], 1'b0, a_t[i], wd_t[i], 5'(7 + i));
      @(negedge clk);
      n_checks++;
      if ({lsu2dtcm_cmd_valid, lsu2dtcm_cmd_read, lsu2dtcm_cmd_addr, lsu2dtcm_cmd_wmask, lsu2dtcm_cmd_wdata}
          !== {1'b1, 1'b0, a_t[i], mk_t[i], cw_t[i]}) begin
        n_fail++;
        $display("FAIL st_cmd[%0d]: valid=%b read=%b addr=%h wmask=%b wdata=%h, want 1 0 %h %b %h", i,
                 lsu2dtcm_cmd_valid, lsu2dtcm_cmd_read, lsu2dtcm_cmd_addr, lsu2dtcm_cmd_wmask,
                 lsu2dtcm_cmd_wdata, a_t[i], mk_t[i], cw_t[i]);
      end
      for (int t = 0; t < 50 && obs.size() == 0; t++) @(negedge clk);
      n_checks++;
      if (obs.size() == 0 || sb.size() == 0) begin
        n_fail++;
        $display("FAIL st_wb[%0d]: observed=%0d expected=%0d entries", i, obs.size(), sb.size());
      end else begin
        o = obs.pop_front(); e = sb.pop_front();
        if (o.rd !== e.rd || o.wen !== e.wen || o.rdata !== e.rdata || o.mis !== e.mis) begin
          n_fail++;
          $display("FAIL st_wb[%0d]: got rd=%0d wen=%b rdata=%h mis=%b, want rd=%0d wen=%b rdata=%h mis=%b",
                   i, o.rd, o.wen, o.rdata, o.mis, e.rd, e.wen, e.rdata, e.mis);
        end
      end
    end
  endtask

  task automatic test_misaligned;
    logic [15:0] a_t  [3] = '{16'h0005, 16'h0003, 16'h0000};
    logic [1:0]  sz_t [3] = '{2'b10, 2'b01, 2'b11};
    int          cmd_before;
    lsu2dtcm_cmd_ready = 1; lsu2dtcm_rsp_valid = 1; lsu2dtcm_rsp_rdata = 32'h12345678; lsu2wb_ready = 1;
    for (int i = 0; i < 3; i++) begin
      cmd_before = cmd_cycles;
      push_exp(5'(20 + i), 1'b0, 32'h0, 1'b1);
      drive_req(1'b1, sz_t[i], 1'b0, a_t[i], 32'h0, 5'(20 + i));
      @(negedge clk);
      n_checks++;
      if ({lsu2wb_valid, lsu2wb_misalign, lsu2dtcm_cmd_valid} !== 3'b110) begin
        n_fail++;
        $display("FAIL mis_latency[%0d]: wbv=%b mis=%b cmdv=%b one cycle after accept, want 1 1 0",
                 i, lsu2wb_valid, lsu2wb_misalign, lsu2dtcm_cmd_valid);
      end
      for (int t = 0; t < 50 && obs.size() == 0; t++) @(negedge clk);
      @(negedge clk);
      n_checks++;
      if (cmd_cycles !== cmd_before) begin
        n_fail++;
        $display("FAIL mis_nocmd[%0d]: %0d command cycles seen, want 0", i, cmd_cycles - cmd_before);
      end
      n_checks++;
      if (obs.size() == 0 || sb.size() == 0) begin
        n_fail++;
        $display("FAIL mis_wb[%0d]: observed=%0d expected=%0d entries", i, obs.size(), sb.size());
      end else begin
        o = obs.pop_front(); e = sb.pop_front();
        if (o.rd !== e.rd || o.wen !== e.wen || o.rdata !== e.rdata || o.mis !== e.mis) begin
          n_fail++;
          $display("FAIL mis_wb[%0d]: got rd=%0d wen=%b rdata=%h mis=%b, want rd=%0d wen=%b rdata=%h mis=%b",
                   i, o.rd, o.wen, o.rdata, o.mis, e.rd, e.wen, e.rdata, e.mis);
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] a_t  [3] = '{16'h0000, 16'h0001, 16'h0002};
    logic [1:0]  sz_t [3] = '{2'b10, 2'b00, 2'b01};
    logic        un_t [3] = '{1'b0, 1'b1, 1'b0};
    logic [31:0] ex_t [3] = '{32'h11223344, 32'h00000033, 32'h00001122};
    time         ts [3];
    lsu2dtcm_cmd_ready = 1; lsu2dtcm_rsp_valid = 1; lsu2dtcm_rsp_rdata = 32'h11223344; lsu2wb_ready = 1;
    for (int i = 0; i < 3; i++) begin
      push_exp(5'(10 + i), 1'b1, ex_t[i], 1'b0);
      drive_req(1'b1, sz_t[i], un_t[i], a_t[i], 32'h0, 5'(10 + i));
      ts[i] = $time;
    end
    n_checks++;
    if ((ts[1] - ts[0]) !== 30 || (ts[2] - ts[1]) !== 30) begin
      n_fail++;
      $display("FAIL b2b_rate: accept spacing %0t and %0t, want 30 and 30", ts[1] - ts[0], ts[2] - ts[1]);
    end
    for (int i = 0; i < 3; i++) begin
      for (int t = 0; t < 50 && obs.size() == 0; t++) @(negedge clk);
      n_checks++;
      if (obs.size() == 0 || sb.size() == 0) begin
        n_fail++;
        $display("FAIL b2b_wb[%0d]: observed=%0d expected=%0d entries", i, obs.size(), sb.size());
      end else begin
        o = obs.pop_front(); e = sb.pop_front();
        if (o.rd !== e.rd || o.wen !== e.wen || o.rdata !== e.rdata || o.mis !== e.mis) begin
          n_fail++;
          $display("FAIL b2b_wb[%0d]: got rd=%0d wen=%b rdata=%h mis=%b, want rd=%0d wen=%b rdata=%h mis=%b",
                   i, o.rd, o.wen, o.rdata, o.mis, e.rd, e.wen, e.rdata, e.mis);
        end
      end
    end
  endtask

  task automatic test_backpressure;
    int comp_before;
    lsu2dtcm_cmd_ready = 0; lsu2dtcm_rsp_valid = 0; lsu2dtcm_rsp_rdata = 32'h0; lsu2wb_ready = 0;
    repeat (2) @(posedge clk);
    comp_before = completions;
    push_exp(5'd12, 1'b1, 32'hFFFFC0DE, 1'b0);
    drive_req(1'b1, SIZE_HALF, 1'b0, 16'h0042, 32'h0, 5'd12);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if ({lsu2dtcm_cmd_valid, lsu2dtcm_cmd_read, lsu2dtcm_cmd_addr, lsu2dtcm_cmd_wmask, exu2lsu_ready}
          !== {1'b1, 1'b1, 16'h0042, 4'b0000, 1'b0}) begin
        n_fail++;
        $display("FAIL bp_cmd_hold[%0d]: valid=%b read=%b addr=%h wmask=%b exu_ready=%b, want 1 1 0042 0000 0",
                 c, lsu2dtcm_cmd_valid, lsu2dtcm_cmd_read, lsu2dtcm_cmd_addr, lsu2dtcm_cmd_wmask, exu2lsu_ready);
      end
    end
    @(posedge clk); #1; lsu2dtcm_cmd_ready = 1;
    @(posedge clk); #1; lsu2dtcm_cmd_ready = 0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_checks++;
      if ({lsu2dtcm_rsp_ready, lsu2dtcm_cmd_valid, lsu2wb_valid, exu2lsu_ready} !== 4'b1000) begin
        n_fail++;
        $display("FAIL bp_rsp_wait[%0d]: rsp_ready=%b cmdv=%b wbv=%b exu_ready=%b, want 1 0 0 0",
                 c, lsu2dtcm_rsp_ready, lsu2dtcm_cmd_valid, lsu2wb_valid, exu2lsu_ready);
      end
      @(posedge clk); #1;
    end
    lsu2dtcm_rsp_valid = 1; lsu2dtcm_rsp_rdata = 32'hC0DE0000;
    @(posedge clk); #1;
    lsu2dtcm_rsp_valid = 0; lsu2dtcm_rsp_rdata = 32'hDEADBEEF;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_checks++;
      if ({lsu2wb_valid, lsu2wb_wen, lsu2wb_rd, lsu2wb_rdata, lsu2wb_misalign, exu2lsu_ready}
          !== {1'b1, 1'b1, 5'd12, 32'hFFFFC0DE, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL bp_wb_hold[%0d]: wbv=%b wen=%b rd=%0d rdata=%h mis=%b exu_ready=%b, want 1 1 12 ffffc0de 0 0",
                 c, lsu2wb_valid, lsu2wb_wen, lsu2wb_rd, lsu2wb_rdata, lsu2wb_misalign, exu2lsu_ready);
      end
      @(posedge clk); #1;
    end
    lsu2wb_ready = 1;
    for (int t = 0; t < 50 && obs.size() == 0; t++) @(negedge clk);
    n_checks++;
    if (obs.size() == 0 || sb.size() == 0) begin
      n_fail++;
      $display("FAIL bp_wb: observed=%0d expected=%0d entries", obs.size(), sb.size());
    end else begin
      o = obs.pop_front(); e = sb.pop_front();
      if (o.rd !== e.rd || o.wen !== e.wen || o.rdata !== e.rdata || o.mis !== e.mis) begin
        n_fail++;
        $display("FAIL bp_wb: got rd=%0d wen=%b rdata=%h mis=%b, want rd=%0d wen=%b rdata=%h mis=%b",
                 o.rd, o.wen, o.rdata, o.mis, e.rd, e.wen, e.rdata, e.mis);
      end
    end
    repeat (4) @(negedge clk);
    n_checks++;
    if ((completions - comp_before) !== 1 || exu2lsu_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_once: completions=%0d exu_ready=%b, want 1 1", completions - comp_before, exu2lsu_ready);
    end
  endtask

  task automatic test_reset_rsp;
    int comp_before;
    lsu2dtcm_cmd_ready = 1; lsu2dtcm_rsp_valid = 0; lsu2dtcm_rsp_rdata = 32'h0; lsu2wb_ready = 1;
    comp_before = completions;
    drive_req(1'b1, SIZE_WORD, 1'b0, 16'h0050, 32'h0, 5'd9);
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if ({lsu2dtcm_rsp_ready, lsu2dtcm_cmd_valid, lsu2wb_valid} !== 3'b100) begin
      n_fail++;
      $display("FAIL rr_in_rsp: rsp_ready=%b cmdv=%b wbv=%b, want 1 0 0",
               lsu2dtcm_rsp_ready, lsu2dtcm_cmd_valid, lsu2wb_valid);
    end
    @(posedge clk); #1; rst_n = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if ({exu2lsu_ready, lsu2dtcm_cmd_valid, lsu2dtcm_cmd_read, lsu2dtcm_rsp_ready, lsu2wb_valid,
         lsu2wb_wen, lsu2wb_misalign, lsu2dtcm_cmd_addr, lsu2dtcm_cmd_wmask, lsu2dtcm_cmd_wdata,
         lsu2wb_rd, lsu2wb_rdata} !== '0) begin
      n_fail++;
      $display("FAIL rr_reset_vals: ready=%b cmdv=%b read=%b rspr=%b wbv=%b wen=%b mis=%b addr=%h rd=%0d rdata=%h, want all zero",
               exu2lsu_ready, lsu2dtcm_cmd_valid, lsu2dtcm_cmd_read, lsu2dtcm_rsp_ready, lsu2wb_valid,
               lsu2wb_wen, lsu2wb_misalign, lsu2dtcm_cmd_addr, lsu2wb_rd, lsu2wb_rdata);
    end
    rst_n = 1'b1;
    lsu2dtcm_rsp_valid = 1; lsu2dtcm_rsp_rdata = 32'hABCDEF01;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if (lsu2wb_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL rr_late_rsp[%0d]: wb_valid=%b after late response, want 0", c, lsu2wb_valid);
      end
      @(posedge clk); #1;
    end
    lsu2dtcm_rsp_valid = 0;
    n_checks++;
    if ((completions - comp_before) !== 0) begin
      n_fail++;
      $display("FAIL rr_dropped: %0d completions from the reset request, want 0", completions - comp_before);
    end
    lsu2dtcm_rsp_valid = 1; lsu2dtcm_rsp_rdata = 32'h5A5A1234;
    push_exp(5'd3, 1'b1, 32'h5A5A1234, 1'b0);
    drive_req(1'b1, SIZE_WORD, 1'b0, 16'h0060, 32'h0, 5'd3);
    for (int t = 0; t < 50 && obs.size() == 0; t++) @(negedge clk);
    n_checks++;
    if (obs.size() == 0 || sb.size() == 0) begin
      n_fail++;
      $display("FAIL rr_next: observed=%0d expected=%0d entries", obs.size(), sb.size());
    end else begin
      o = obs.pop_front(); e = sb.pop_front();
      if (o.rd !== e.rd || o.wen !== e.wen || o.rdata !== e.rdata || o.mis !== e.mis) begin
        n_fail++;
        $display("FAIL rr_next: got rd=%0d wen=%b rdata=%h mis=%b, want rd=%0d wen=%b rdata=%h mis=%b",
                 o.rd, o.wen, o.rdata, o.mis, e.rd, e.wen, e.rdata, e.mis);
      end
    end
  endtask

  initial begin
    test_reset;
    test_ld_extract;
    test_load_word;
    test_load_byte;
    test_store;
    test_misaligned;
    test_back_to_back;
    test_backpressure;
    test_reset_rsp;
    repeat (3) @(negedge clk);
    n_checks++;
    if (obs.size() !== 0 || sb.size() !== 0) begin
      n_fail++;
      $display("FAIL drain: %0d unchecked completions, %0d outstanding expectations, want 0 0",
               obs.size(), sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
